// File: rtl/full_adder_cell_pkg.sv
// Shared constants and the pipeline-stage record for full_adder_cell.
package full_adder_cell_pkg;

    localparam int LATENCY_MAX = 4;
    localparam int STAT_W      = 16;

    typedef struct packed {
        logic sum;
        logic cout;
        logic valid;
    } fa_stage_t;

endpackage : full_adder_cell_pkg

// File: rtl/full_adder_cell_fa_core.sv
// Purely combinational one-bit full adder shared by the chaining outputs and the pipeline.
module fa_core (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_core

// File: rtl/full_adder_cell.sv
// Full adder with combinational chaining outputs and a LATENCY-deep valid-tracked result pipeline.
// Optional statistics counters are built when FULL_ADDER_CELL_STATS_EN is defined.
module full_adder_cell
    import full_adder_cell_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic in_valid,
    output logic sum_comb,
    output logic cout_comb,
    output logic sum,
    output logic cout,
    output logic out_valid
`ifdef FULL_ADDER_CELL_STATS_EN
    ,
    output logic [STAT_W-1:0] op_count,
    output logic [STAT_W-1:0] carry_count
`endif
);

    // Handshake: inputs are taken on every rising edge where in_valid=1; there is no
    // ready, so the cell never stalls. out_valid pulses for one cycle per result.

    logic core_sum;
    logic core_cout;

    fa_core u_core (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (core_sum),
        .cout (core_cout)
    );

    assign sum_comb  = core_sum;
    assign cout_comb = core_cout;

    fa_stage_t stage_q [LATENCY];
    fa_stage_t stage_d [LATENCY];

    // Data only moves with its valid bit, so an idle stage keeps its last result.
    always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
            stage_d[k] = stage_q[k];
        end
        stage_d[0].valid = in_valid;
        if (in_valid) begin
            stage_d[0].sum  = core_sum;
            stage_d[0].cout = core_cout;
        end
        for (int k = 1; k < LATENCY; k++) begin
            stage_d[k].valid = stage_q[k-1].valid;
            if (stage_q[k-1].valid) begin
                stage_d[k].sum  = stage_q[k-1].sum;
                stage_d[k].cout = stage_q[k-1].cout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign sum       = stage_q[LATENCY-1].sum;
    assign cout      = stage_q[LATENCY-1].cout;
    assign out_valid = stage_q[LATENCY-1].valid;

`ifdef FULL_ADDER_CELL_STATS_EN
    logic [STAT_W-1:0] op_count_q;
    logic [STAT_W-1:0] op_count_d;
    logic [STAT_W-1:0] carry_count_q;
    logic [STAT_W-1:0] carry_count_d;

    // Counted at accept time; both wrap naturally at 2^STAT_W.
    always_comb begin
        op_count_d    = op_count_q;
        carry_count_d = carry_count_q;
        if (in_valid) begin
            op_count_d = op_count_q + STAT_W'(1);
            if (core_cout) begin
                carry_count_d = carry_count_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q    <= '0;
            carry_count_q <= '0;
        end else begin
            op_count_q    <= op_count_d;
            carry_count_q <= carry_count_d;
        end
    end

    assign op_count    = op_count_q;
    assign carry_count = carry_count_q;
`endif

endmodule : full_adder_cell

// File: tb/tb_full_adder_cell.sv
// Directed bench for full_adder_cell: three instances (LATENCY 1, 3, 4) share one stimulus stream.
// Statistics checks are compiled only when FULL_ADDER_CELL_STATS_EN is defined.
module tb_full_adder_cell;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic cin;
    logic in_valid;

    logic sc1, cc1, s1, c1, v1;
    logic sc3, cc3, s3, c3, v3;
    logic sc4, cc4, s4, c4, v4;
`ifdef FULL_ADDER_CELL_STATS_EN
    logic [15:0] opc1, cac1, opc3, cac3, opc4, cac4;
`endif

    int checks;
    int errors;

    full_adder_cell #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum_comb(sc1), .cout_comb(cc1), .sum(s1), .cout(c1), .out_valid(v1)
`ifdef FULL_ADDER_CELL_STATS_EN
        , .op_count(opc1), .carry_count(cac1)
`endif
    );

    full_adder_cell #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum_comb(sc3), .cout_comb(cc3), .sum(s3), .cout(c3), .out_valid(v3)
`ifdef FULL_ADDER_CELL_STATS_EN
        , .op_count(opc3), .carry_count(cac3)
`endif
    );

    full_adder_cell #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum_comb(sc4), .cout_comb(cc4), .sum(s4), .cout(c4), .out_valid(v4)
`ifdef FULL_ADDER_CELL_STATS_EN
        , .op_count(opc4), .carry_count(cac4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic va, input logic vb, input logic vc, input logic vv);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = vv;
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Hand-computed {cout,sum} for {a,b,cin} = 0..7
    logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        logic [2:0] abc;
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // Reset state of every instance
        check("rst_l1_outs", {13'd0, s1, c1, v1}, 16'd0);
        check("rst_l3_outs", {13'd0, s3, c3, v3}, 16'd0);
        check("rst_l4_outs", {13'd0, s4, c4, v4}, 16'd0);
`ifdef FULL_ADDER_CELL_STATS_EN
        check("rst_op_count", opc1, 16'h0000);
        check("rst_carry_count", cac1, 16'h0000);
`endif
        // Combinational path stays alive during reset
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        check("rst_comb_110", {14'd0, cc1, sc1}, 16'h0002);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_comb_100", {14'd0, cc4, sc4}, 16'h0001);
        tick();
        check("rst_hold_l1", {13'd0, s1, c1, v1}, 16'd0);
        rst = 1'b0;

        // Exhaustive, back-to-back, LATENCY=1; first accept on first edge after release
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            drive(abc[2], abc[1], abc[0], 1'b1);
            #1;
            check($sformatf("comb_%0d", i), {14'd0, cc1, sc1}, {14'd0, exp_tab[i]});
            tick();
            check($sformatf("reg_%0d", i), {14'd0, c1, s1}, {14'd0, exp_tab[i]});
            check($sformatf("ov_%0d", i), {15'd0, v1}, 16'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ov_after_burst", {15'd0, v1}, 16'd0);
        check("hold_after_burst", {14'd0, c1, s1}, 16'h0003);

        // Latency 3: single valid pulse, out_valid only after the third edge
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int e = 1; e <= 6; e++) begin
            tick();
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("lat3_ov_e%0d", e), {15'd0, v3}, (e == 3) ? 16'd1 : 16'd0);
            if (e < 3) check($sformatf("lat3_data_e%0d", e), {14'd0, c3, s3}, 16'd0);
            if (e == 3) check("lat3_data_e3", {14'd0, c3, s3}, 16'h0003);
        end

        // Gaps on LATENCY=1: valid 1,0,1
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("gap_op1", {13'd0, v1, c1, s1}, 16'h0005);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("gap_bubble", {13'd0, v1, c1, s1}, 16'h0001);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("gap_op2", {13'd0, v1, c1, s1}, 16'h0006);

        // Reset mid-flight on LATENCY=4
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_l1_before", {13'd0, v1, c1, s1}, 16'h0005);
        #2;
        rst = 1'b1;
        #1;
        check("mid_l1_async_clear", {13'd0, v1, c1, s1}, 16'd0);
        check("mid_l4_async_clear", {13'd0, v4, c4, s4}, 16'd0);
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("mid_l4_no_ov_e%0d", e), {15'd0, v4}, 16'd0);
        end
        check("mid_l4_data_zero", {14'd0, c4, s4}, 16'd0);

`ifdef FULL_ADDER_CELL_STATS_EN
        // 65537 carrying ops: both counters wrap to 1
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 65537; n++) begin
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("stats_op_wrap", opc1, 16'h0001);
        check("stats_carry_wrap", cac1, 16'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_full_adder_cell
